regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised multi-read-port integer register file for the pipelined RISC-V datapath, with an optional write-to-read bypass and a per-register scoreboard of pending writes. The decode stage reads operands and busy flags from it. Issue reserves a destination register; writeback fills it and releases the reservation. It replaces the fixed two-port, 32×32 register file and gives the hazard unit a stall source.

## Interface
Parameters:
- `N` — default 32 — data width in bits.
- `DEPTH` — default 32 — number of registers; must be a power of two, ≥ 2.
- `AW` — default $clog2(DEPTH) — address width; derived, not overridden.
- `NREAD` — default 2 — number of read ports, 1..4.
- `BYPASS` — default 1 — 1: same-cycle write data is forwarded to matching reads; 0: reads see array contents only.
- `ZERO_REG` — default 1 — 1: register 0 reads 0, ignores writes, and is never busy.

Ports:
- `clk` — in — 1 — single clock; all state updates on the rising edge.
- `reset` — in — 1 — asynchronous, active-high.
- `write` — in — 1 — writeback enable.
- `write_address` — in — AW — writeback destination.
- `write_data` — in — N — writeback value.
- `reserve` — in — 1 — issue enable; marks `reserve_address` busy.
- `reserve_address` — in — AW — destination being issued.
- `read_address` — in — NREAD*AW — port k occupies bits [k*AW +: AW].
- `read_data` — out — NREAD*N — port k occupies bits [k*N +: N].
- `read_busy` — out — NREAD — port k's register has a pending write.
- `pending_count` — out — AW+1 — number of busy registers.
- `reserve_conflict` — out — 1 — a reserve was issued to an already-busy register.

## Operation
- **Storage:** DEPTH×N array and DEPTH busy bits.
- **Write:** on the clock edge, if `write` is high and the target is not the zero register (when ZERO_REG=1), store `write_data` and clear the target's busy bit.
- **Reserve:** on the clock edge, if `reserve` is high and the target is not the zero register (when ZERO_REG=1), set the target's busy bit.
- **Reserve and write to the same address in one cycle:** reserve wins; busy stays set (a newer producer exists) and the data is still written.
- **Re-reserving a busy register:** legal. Busy stays 1, `pending_count` is unchanged, and `reserve_conflict` pulses for one cycle (registered). There is no per-register producer count; the hazard unit must not issue WAW.
- **Write to a non-busy register:** legal (e.g. a CSR path). Data is stored and `pending_count` is unchanged.
- **`pending_count`:** registered. Next value = current + (reserve sets a previously-clear bit) − (write clears a set bit that is not re-reserved in the same cycle). Never exceeds DEPTH−ZERO_REG and never underflows.
- **Reads:** combinational. `read_data[k]` = 0 if ZERO_REG=1 and the address is 0. Otherwise, if BYPASS=1, `write` is high and the address matches `write_address`, it returns `write_data`. Otherwise it returns the array entry.
- **`read_busy[k]`:** the busy bit of the addressed register, except:
  - 0 when BYPASS=1 and a same-cycle write to that address is present, unless that address is also being reserved this cycle (the reserve is for a later producer and does not affect this cycle's read);
  - always 0 for register 0 when ZERO_REG=1.
- **Reset:** clears all registers, all busy bits, `pending_count` and `reserve_conflict`. Reset asserted mid-operation discards pending reservations; in-flight writes in the same cycle are lost.

## Timing
- **Reset values:** `read_data` = 0 on every port, `read_busy` = 0, `pending_count` = 0, `reserve_conflict` = 0. These apply immediately on reset assertion, with no clock needed.
- **Read latency:** 0 cycles (combinational from address, and from `write`/`write_data` when BYPASS=1).
- **Write visibility:**
  - BYPASS=1: same cycle via the bypass, then from the array from the next edge on.
  - BYPASS=0: from the next edge on.
- **Reserve visibility:** `read_busy` rises after the edge that samples `reserve`. `pending_count` and `reserve_conflict` update on that same edge.
- **No internal pipeline:** no handshake and no backpressure; the block accepts one write and one reserve every cycle.

## Test plan
1. **Reset:** write reg5=0xDEADBEEF, then assert `reset` asynchronously between edges → `read_data` for reg5 reads 0 immediately, and `pending_count`=0.
2. **Bypass:** with BYPASS=1, drive `write`=1, addr 7, data 0x1234, and read port 1 at addr 7 in the same cycle → port 1 reads 0x1234 before the edge. With BYPASS=0 → the old value before the edge, 0x1234 after it.
3. **Scoreboard:** reserve reg3 → `read_busy` high for a port reading 3 and `pending_count`=1. Write reg3=0x55 two cycles later → busy low in that write cycle (BYPASS=1) and `pending_count`=0 after the edge.
4. **Simultaneous reserve and write to reg9 (busy):** busy stays 1, data is written, `pending_count` is unchanged, and the port reading 9 shows busy=1 with data 0xAA (bypassed).
5. **Zero register:** reserve 0 and write 0 with data 0xFFFFFFFF → reads 0, busy 0, `pending_count` 0. Re-reserve busy reg4 → `reserve_conflict`=1 for one cycle and the count is unchanged.
6. **Saturation:** reserve regs 1..31 on consecutive cycles → `pending_count`=31. Write all of them back → the count returns to 0 with no underflow when extra writes go to non-busy registers. Repeat with NREAD=4, DEPTH=16, N=16.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Multi-read-port integer register file with a per-register scoreboard of
// pending writes. Decode reads operands and busy flags combinationally, issue
// reserves a destination, and writeback fills it and releases the reservation.
module regfile_scoreboard #(
    parameter int N        = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int NREAD    = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [AW-1:0]         write_address,
    input  logic [N-1:0]          write_data,
    input  logic                  reserve,
    input  logic [AW-1:0]         reserve_address,
    input  logic [NREAD*AW-1:0]   read_address,
    output logic [NREAD*N-1:0]    read_data,
    output logic [NREAD-1:0]      read_busy,
    output logic [AW:0]           pending_count,
    output logic                  reserve_conflict
);

    // Register 0 is hardwired to zero (and never busy) when ZERO_REG is set.
    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == {AW{1'b0}});
    endfunction

    logic [N-1:0]     mem_r [DEPTH];
    logic [DEPTH-1:0] busy_r;
    logic [AW:0]      count_r;
    logic             conflict_r;

    logic             wr_en_s;
    logic             rsv_en_s;
    logic             inc_s;
    logic             dec_s;
    logic             conflict_s;

    // Qualify write/reserve and derive the scoreboard count deltas.
    always_comb begin
        wr_en_s    = write && !is_zero_reg(write_address);
        rsv_en_s   = reserve && !is_zero_reg(reserve_address);
        // Only a reserve that sets a previously-clear bit grows the count.
        inc_s      = rsv_en_s && !busy_r[reserve_address];
        // A write releases a reservation unless the same register is re-reserved now.
        dec_s      = wr_en_s && busy_r[write_address]
                     && !(rsv_en_s && (reserve_address == write_address));
        conflict_s = rsv_en_s && busy_r[reserve_address];
    end

    // Register array storage; writeback stores data into the target entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {N{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[write_address] <= write_data;
        end
    end

    // Busy bits: writeback clears, reserve sets; reserve is applied last so it wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            if (wr_en_s) begin
                busy_r[write_address] <= 1'b0;
            end
            if (rsv_en_s) begin
                busy_r[reserve_address] <= 1'b1;
            end
        end
    end

    // Pending-write counter and one-cycle re-reservation pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r    <= {(AW+1){1'b0}};
            conflict_r <= 1'b0;
        end else begin
            count_r    <= count_r + {{AW{1'b0}}, inc_s} - {{AW{1'b0}}, dec_s};
            conflict_r <= conflict_s;
        end
    end

    assign pending_count    = count_r;
    assign reserve_conflict = conflict_r;

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [AW-1:0] addr_s;
        logic [N-1:0]  data_s;
        logic          busy_s;
        logic          hit_s;

        assign addr_s = read_address[k*AW +: AW];

        // Combinational read port with optional same-cycle write forwarding.
        always_comb begin
            hit_s = (BYPASS != 0) && write && (write_address == addr_s);
            if (reset || is_zero_reg(addr_s)) begin
                data_s = {N{1'b0}};
                busy_s = 1'b0;
            end else if (hit_s) begin
                data_s = write_data;
                // The forwarded write satisfies this read unless a newer producer
                // is being issued to the same register this cycle.
                if (rsv_en_s && (reserve_address == addr_s)) begin
                    busy_s = busy_r[addr_s];
                end else begin
                    busy_s = 1'b0;
                end
            end else begin
                data_s = mem_r[addr_s];
                busy_s = busy_r[addr_s];
            end
        end

        assign read_data[k*N +: N] = data_s;
        assign read_busy[k]        = busy_s;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard: a default instance
// (32x32, 2 ports, bypass) and a small one (16x16, 4 ports, no bypass).
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // Instance A: defaults
    logic        a_write;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        a_rsv;
    logic [4:0]  a_raddr;
    logic [9:0]  a_rdaddr;
    logic [63:0] a_rdata;
    logic [1:0]  a_busy;
    logic [5:0]  a_cnt;
    logic        a_conf;

    // Instance B: N=16, DEPTH=16, NREAD=4, BYPASS=0
    logic        b_write;
    logic [3:0]  b_waddr;
    logic [15:0] b_wdata;
    logic        b_rsv;
    logic [3:0]  b_raddr;
    logic [15:0] b_rdaddr;
    logic [63:0] b_rdata;
    logic [3:0]  b_busy;
    logic [4:0]  b_cnt;
    logic        b_conf;

    regfile_scoreboard dut_a (
        .clk(clk), .reset(reset),
        .write(a_write), .write_address(a_waddr), .write_data(a_wdata),
        .reserve(a_rsv), .reserve_address(a_raddr),
        .read_address(a_rdaddr), .read_data(a_rdata), .read_busy(a_busy),
        .pending_count(a_cnt), .reserve_conflict(a_conf)
    );

    regfile_scoreboard #(.N(16), .DEPTH(16), .NREAD(4), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .reset(reset),
        .write(b_write), .write_address(b_waddr), .write_data(b_wdata),
        .reserve(b_rsv), .reserve_address(b_raddr),
        .read_address(b_rdaddr), .read_data(b_rdata), .read_busy(b_busy),
        .pending_count(b_cnt), .reserve_conflict(b_conf)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        a_write  = 1'b0; a_waddr = 5'd0; a_wdata = 32'd0;
        a_rsv    = 1'b0; a_raddr = 5'd0; a_rdaddr = {5'd5, 5'd7};
        b_write  = 1'b0; b_waddr = 4'd0; b_wdata = 16'd0;
        b_rsv    = 1'b0; b_raddr = 4'd0; b_rdaddr = 16'd0;
        #2;
        check("rst_a_rdata", a_rdata, 64'd0);
        check("rst_a_busy", {62'd0, a_busy}, 64'd0);
        check("rst_a_cnt", {58'd0, a_cnt}, 64'd0);
        check("rst_a_conf", {63'd0, a_conf}, 64'd0);
        check("rst_b_cnt", {59'd0, b_cnt}, 64'd0);
        check("rst_b_conf", {63'd0, b_conf}, 64'd0);
        #1 reset = 1'b0;
        tick();

        // 1. write reg5, reserve reg6, then asynchronous reset between edges
        a_write = 1'b1; a_waddr = 5'd5; a_wdata = 32'hDEADBEEF;
        a_rsv   = 1'b1; a_raddr = 5'd6;
        tick();
        a_write = 1'b0; a_rsv = 1'b0;
        a_rdaddr = {5'd6, 5'd5};
        #1;
        check("t1_reg5", {32'd0, a_rdata[31:0]}, 64'hDEADBEEF);
        check("t1_cnt", {58'd0, a_cnt}, 64'd1);
        check("t1_busy6", {63'd0, a_busy[1]}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check("t1_rst_reg5", {32'd0, a_rdata[31:0]}, 64'd0);
        check("t1_rst_cnt", {58'd0, a_cnt}, 64'd0);
        check("t1_rst_busy6", {63'd0, a_busy[1]}, 64'd0);
        reset = 1'b0;
        tick();

        // 2. bypass vs no bypass on reg7
        a_write = 1'b1; a_waddr = 5'd7; a_wdata = 32'h1111;
        b_write = 1'b1; b_waddr = 4'd7; b_wdata = 16'h1111;
        tick();
        a_wdata  = 32'h1234; b_wdata = 16'h1234;
        a_rdaddr = {5'd7, 5'd0};
        b_rdaddr = {4'd0, 4'd0, 4'd7, 4'd0};
        #1;
        check("t2_a_bypass", {32'd0, a_rdata[63:32]}, 64'h1234);
        check("t2_b_old", {48'd0, b_rdata[31:16]}, 64'h1111);
        tick();
        a_write = 1'b0; b_write = 1'b0;
        #1;
        check("t2_b_new", {48'd0, b_rdata[31:16]}, 64'h1234);
        check("t2_a_array", {32'd0, a_rdata[63:32]}, 64'h1234);

        // 3. scoreboard reserve then write two cycles later
        a_rsv = 1'b1; a_raddr = 5'd3; a_rdaddr = {5'd0, 5'd3};
        tick();
        a_rsv = 1'b0;
        #1;
        check("t3_busy", {63'd0, a_busy[0]}, 64'd1);
        check("t3_cnt1", {58'd0, a_cnt}, 64'd1);
        tick();
        a_write = 1'b1; a_waddr = 5'd3; a_wdata = 32'h55;
        #1;
        check("t3_busy_wr", {63'd0, a_busy[0]}, 64'd0);
        check("t3_data_wr", {32'd0, a_rdata[31:0]}, 64'h55);
        check("t3_cnt_pre", {58'd0, a_cnt}, 64'd1);
        tick();
        a_write = 1'b0;
        #1;
        check("t3_cnt0", {58'd0, a_cnt}, 64'd0);
        check("t3_busy_after", {63'd0, a_busy[0]}, 64'd0);

        // 4. simultaneous reserve and write to busy reg9
        a_rsv = 1'b1; a_raddr = 5'd9;
        tick();
        a_write = 1'b1; a_waddr = 5'd9; a_wdata = 32'hAA;
        a_rdaddr = {5'd9, 5'd0};
        #1;
        check("t4_busy_same", {63'd0, a_busy[1]}, 64'd1);
        check("t4_data_bypass", {32'd0, a_rdata[63:32]}, 64'hAA);
        check("t4_cnt_pre", {58'd0, a_cnt}, 64'd1);
        tick();
        a_write = 1'b0; a_rsv = 1'b0;
        #1;
        check("t4_cnt", {58'd0, a_cnt}, 64'd1);
        check("t4_conf", {63'd0, a_conf}, 64'd1);
        check("t4_busy", {63'd0, a_busy[1]}, 64'd1);
        check("t4_data", {32'd0, a_rdata[63:32]}, 64'hAA);
        tick();
        check("t4_conf_drop", {63'd0, a_conf}, 64'd0);
        a_write = 1'b1; a_waddr = 5'd9; a_wdata = 32'hAB;
        tick();
        a_write = 1'b0;
        #1;
        check("t4_cnt0", {58'd0, a_cnt}, 64'd0);

        // 5. zero register and re-reserve conflict
        a_rsv = 1'b1; a_raddr = 5'd0;
        a_write = 1'b1; a_waddr = 5'd0; a_wdata = 32'hFFFFFFFF;
        a_rdaddr = {5'd0, 5'd0};
        #1;
        check("t5_zero_data", {32'd0, a_rdata[31:0]}, 64'd0);
        check("t5_zero_busy", {63'd0, a_busy[0]}, 64'd0);
        tick();
        a_rsv = 1'b0; a_write = 1'b0;
        #1;
        check("t5_zero_cnt", {58'd0, a_cnt}, 64'd0);
        check("t5_zero_conf", {63'd0, a_conf}, 64'd0);
        check("t5_zero_after", {32'd0, a_rdata[31:0]}, 64'd0);
        a_rsv = 1'b1; a_raddr = 5'd4;
        tick();
        check("t5_r4_cnt", {58'd0, a_cnt}, 64'd1);
        check("t5_r4_conf0", {63'd0, a_conf}, 64'd0);
        tick();
        a_rsv = 1'b0;
        #1;
        check("t5_conf", {63'd0, a_conf}, 64'd1);
        check("t5_cnt_same", {58'd0, a_cnt}, 64'd1);
        tick();
        check("t5_conf_pulse", {63'd0, a_conf}, 64'd0);
        a_write = 1'b1; a_waddr = 5'd4; a_wdata = 32'h44;
        tick();
        a_write = 1'b0;
        #1;
        check("t5_cnt0", {58'd0, a_cnt}, 64'd0);

        // 6a. saturation on instance A
        for (int i = 1; i < 32; i++) begin
            a_rsv = 1'b1; a_raddr = 5'(i);
            tick();
        end
        a_rsv = 1'b0;
        a_rdaddr = {5'd31, 5'd1};
        #1;
        check("t6a_cnt31", {58'd0, a_cnt}, 64'd31);
        check("t6a_busy", {62'd0, a_busy}, 64'd3);
        for (int i = 1; i < 17; i++) begin
            a_write = 1'b1; a_waddr = 5'(i); a_wdata = 32'(i * 3);
            tick();
        end
        check("t6a_cnt15", {58'd0, a_cnt}, 64'd15);
        for (int i = 17; i < 32; i++) begin
            a_write = 1'b1; a_waddr = 5'(i); a_wdata = 32'(i * 3);
            tick();
        end
        a_waddr = 5'd10; a_wdata = 32'h10;
        tick();
        a_waddr = 5'd20; a_wdata = 32'h77;
        tick();
        a_write = 1'b0;
        a_rdaddr = {5'd20, 5'd17};
        #1;
        check("t6a_cnt0", {58'd0, a_cnt}, 64'd0);
        check("t6a_rdata", a_rdata, 64'h00000077_00000033);

        // 6b. saturation on instance B
        for (int i = 1; i < 16; i++) begin
            b_rsv = 1'b1; b_raddr = 4'(i);
            tick();
        end
        b_rsv = 1'b0;
        b_rdaddr = {4'd15, 4'd14, 4'd2, 4'd1};
        #1;
        check("t6b_cnt15", {59'd0, b_cnt}, 64'd15);
        check("t6b_busy", {60'd0, b_busy}, 64'hF);
        for (int i = 1; i < 16; i++) begin
            b_write = 1'b1; b_waddr = 4'(i); b_wdata = 16'(i * 16'h0101);
            tick();
        end
        b_waddr = 4'd3; b_wdata = 16'h3333;
        tick();
        b_write = 1'b0;
        b_rdaddr = {4'd15, 4'd0, 4'd3, 4'd1};
        #1;
        check("t6b_cnt0", {59'd0, b_cnt}, 64'd0);
        check("t6b_busy0", {60'd0, b_busy}, 64'd0);
        check("t6b_rdata", b_rdata, 64'h0F0F_0000_3333_0101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
